// File: rtl/data_bus_demux.sv
// data_bus_demux: address-decoded 1:N bus demultiplexer with in-order
// response tracking. A small FIFO of target ids records every accepted
// request. Responses are returned strictly in the order the requests
// were granted.
// Optional integrity sideband: define DATA_BUS_INTG_EN to add the
// *_intg ports, which follow the wdata/rdata paths.
module data_bus_demux #(
    parameter int NUM_SLAVES      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m_req,
    input  logic                     m_we,
    input  logic [3:0]               m_be,
    input  logic [ADDR_WIDTH-1:0]    m_addr,
    input  logic [31:0]              m_wdata,
    output logic                     m_gnt,
    output logic                     m_rvalid,
    output logic                     m_err,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_req,
    output logic                     s_we,
    output logic [3:0]               s_be,
    output logic [ADDR_WIDTH-1:0]    s_addr,
    output logic [31:0]              s_wdata,
    input  logic [NUM_SLAVES-1:0]    s_gnt,
    input  logic [NUM_SLAVES-1:0]    s_rvalid,
    input  logic [NUM_SLAVES-1:0]    s_err,
`ifdef DATA_BUS_INTG_EN
    input  logic [6:0]               m_wdata_intg,
    output logic [6:0]               s_wdata_intg,
    input  logic [NUM_SLAVES*7-1:0]  s_rdata_intg,
    output logic [6:0]               m_rdata_intg,
`endif
    input  logic [NUM_SLAVES*32-1:0] s_rdata
);

    localparam int TW = $clog2(NUM_SLAVES + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    // Target id NUM_SLAVES marks a decode error in the tracking FIFO.
    localparam logic [TW-1:0] ERR_ID = TW'(NUM_SLAVES);

`ifdef DATA_BUS_INTG_EN
    // The SECDED code is linear, so the check bits of an all-zero word are zero.
    localparam logic [6:0] SECDED_ZERO = 7'h00;
`endif

    logic [TW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tail_q;

    logic          hit_any;
    logic [TW-1:0] req_tgt;
    logic [TW-1:0] head;
    logic          sel_gnt;
    logic          full, empty;
    logic          accept_ok;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // Address decode: scan from the top so the lowest matching index wins.
    always_comb begin
        hit_any = 1'b0;
        req_tgt = ERR_ID;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                hit_any = 1'b1;
                req_tgt = TW'(i);
            end
        end
    end

    // Acceptance: room in the FIFO and no change of target while responses
    // are pending. Gated by rst_n so nothing is granted while held in reset.
    assign accept_ok = rst_n & ~full & (empty | (tail_q == req_tgt));

    // Request routing and grant selection for the decoded target.
    always_comb begin
        s_req   = '0;
        sel_gnt = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (req_tgt == TW'(i)) begin
                s_req[i] = m_req & hit_any & accept_ok;
                sel_gnt  = s_gnt[i];
            end
        end
    end

    assign m_gnt   = accept_ok & (hit_any ? sel_gnt : m_req);
    assign push    = m_req & m_gnt;
    assign s_we    = m_we;
    assign s_be    = m_be;
    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
`ifdef DATA_BUS_INTG_EN
    assign s_wdata_intg = m_wdata_intg;
`endif

    // Response mux driven by the FIFO head; responses from other slaves are ignored.
    always_comb begin
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_rdata  = '0;
`ifdef DATA_BUS_INTG_EN
        m_rdata_intg = '0;
`endif
        if (!empty) begin
            if (head == ERR_ID) begin
                m_rvalid = 1'b1;
                m_err    = 1'b1;
`ifdef DATA_BUS_INTG_EN
                m_rdata_intg = SECDED_ZERO;
`endif
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (head == TW'(i)) begin
                        m_rvalid = s_rvalid[i];
                        m_err    = s_err[i];
                        m_rdata  = s_rdata[i*32 +: 32];
`ifdef DATA_BUS_INTG_EN
                        m_rdata_intg = s_rdata_intg[i*7 +: 7];
`endif
                    end
                end
            end
        end
    end

    assign pop = m_rvalid;

    // Occupancy next state: a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Tracking FIFO state; reset discards every outstanding entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tail_q   <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= req_tgt;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                tail_q           <= req_tgt;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_data_bus_demux.sv
// Bench for data_bus_demux: two slaves at 0x0000 and 0x1000 (4 KiB each),
// two outstanding entries. Directed table, reset sequence, then random
// traffic against a queue-based reference model.
module tb_data_bus_demux;

    localparam int NS   = 2;
    localparam int AW   = 32;
    localparam int MAXO = 2;
    localparam logic [NS-1:0][AW-1:0] BASE = {32'h0000_1000, 32'h0000_0000};
    localparam logic [NS-1:0][AW-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_F000};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m_req, m_we;
    logic [3:0]    m_be;
    logic [31:0]   m_addr, m_wdata;
    logic          m_gnt, m_rvalid, m_err;
    logic [31:0]   m_rdata;
    logic [NS-1:0] s_req;
    logic          s_we;
    logic [3:0]    s_be;
    logic [31:0]   s_addr, s_wdata;
    logic [NS-1:0] s_gnt, s_rvalid, s_err;
    logic [NS*32-1:0] s_rdata;

    data_bus_demux #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: queue of outstanding target ids (2 = decode error).
    int q[$];
    bit exp_push, exp_pop;
    int exp_tgt;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [1:0]  sgnt, srv, serr;
        logic [31:0] rd0, rd1;
        logic        gnt;
        logic [1:0]  sreq;
        logic        rvalid, err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        int page;
        page = int'(a >> 12);
        if (page == 0) return 0;
        if (page == 1) return 1;
        return 2;
    endfunction

    task automatic drive(input logic req, input logic [31:0] addr, input logic [1:0] sgnt,
                         input logic [1:0] srv, input logic [1:0] serr,
                         input logic [31:0] rd0, input logic [31:0] rd1);
        @(negedge clk);
        m_req    = req;
        m_addr   = addr;
        m_we     = 1'($urandom);
        m_be     = 4'($urandom);
        m_wdata  = $urandom;
        s_gnt    = sgnt;
        s_rvalid = srv;
        s_err    = serr;
        s_rdata  = {rd1, rd0};
        #1;
    endtask

    task automatic model_check();
        int t;
        bit acc, e_gnt, e_rv, e_err;
        logic [1:0]  e_sreq;
        logic [31:0] e_rd;
        t     = decode(m_addr);
        acc   = (rst_n === 1'b1) && (q.size() < MAXO) && (q.size() == 0 || q[$] == t);
        e_gnt = acc && ((t < NS) ? s_gnt[t] : m_req);
        e_sreq = (m_req && acc && t < NS) ? 2'(1 << t) : 2'b00;
        e_rv = 0; e_err = 0; e_rd = '0;
        if (q.size() != 0) begin
            if (q[0] == NS) begin
                e_rv = 1; e_err = 1;
            end else begin
                e_rv  = s_rvalid[q[0]];
                e_err = s_err[q[0]];
                e_rd  = (q[0] == 1) ? s_rdata[63:32] : s_rdata[31:0];
            end
        end
        chk("mdl_gnt",    32'(m_gnt),    32'(e_gnt));
        chk("mdl_sreq",   32'(s_req),    32'(e_sreq));
        chk("mdl_rvalid", 32'(m_rvalid), 32'(e_rv));
        chk("mdl_err",    32'(m_err),    32'(e_err));
        chk("mdl_rdata",  m_rdata,       e_rd);
        chk("bcast_ctl",  {27'd0, s_we, s_be}, {27'd0, m_we, m_be});
        chk("bcast_addr", s_addr,  m_addr);
        chk("bcast_wd",   s_wdata, m_wdata);
        exp_push = m_req && e_gnt;
        exp_pop  = e_rv;
        exp_tgt  = t;
    endtask

    task automatic model_step();
        @(posedge clk);
        if (exp_pop) void'(q.pop_front());
        if (exp_push) q.push_back(exp_tgt);
    endtask

    initial begin
        // req addr sgnt srv serr rd0 rd1 | gnt sreq rvalid err rdata
        tbl[0]  = '{0, 32'h0000, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        0, 2'b00, 0, 0, 32'h0};
        tbl[1]  = '{1, 32'h1004, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0,        1, 2'b10, 0, 0, 32'h0};
        tbl[2]  = '{0, 32'h1004, 2'b00, 2'b10, 2'b00, 32'h0, 32'hCAFE0001, 0, 2'b00, 1, 0, 32'hCAFE0001};
        tbl[3]  = '{1, 32'h8000, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        1, 2'b00, 0, 0, 32'h0};
        tbl[4]  = '{0, 32'h8000, 2'b00, 2'b11, 2'b11, 32'h12345678, 32'h9ABCDEF0, 0, 2'b00, 1, 1, 32'h0};
        tbl[5]  = '{1, 32'h0010, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0,        1, 2'b01, 0, 0, 32'h0};
        tbl[6]  = '{1, 32'h0010, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0,        1, 2'b01, 0, 0, 32'h0};
        tbl[7]  = '{1, 32'h0010, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0,        0, 2'b00, 0, 0, 32'h0};
        tbl[8]  = '{1, 32'h0010, 2'b01, 2'b01, 2'b00, 32'h11110000, 32'h0, 0, 2'b00, 1, 0, 32'h11110000};
        tbl[9]  = '{1, 32'h0010, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0,        1, 2'b01, 0, 0, 32'h0};
        tbl[10] = '{0, 32'h0010, 2'b00, 2'b01, 2'b00, 32'h22220000, 32'h0, 0, 2'b00, 1, 0, 32'h22220000};
        tbl[11] = '{0, 32'h0010, 2'b00, 2'b01, 2'b01, 32'h33330000, 32'h0, 0, 2'b00, 1, 1, 32'h33330000};
        tbl[12] = '{1, 32'h0020, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0,        1, 2'b01, 0, 0, 32'h0};
        tbl[13] = '{1, 32'h1000, 2'b10, 2'b10, 2'b00, 32'h0, 32'h77770000, 0, 2'b00, 0, 0, 32'h0};
        tbl[14] = '{1, 32'h1000, 2'b10, 2'b01, 2'b00, 32'h44440000, 32'h0, 0, 2'b00, 1, 0, 32'h44440000};
        tbl[15] = '{1, 32'h1000, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0,        1, 2'b10, 0, 0, 32'h0};
        tbl[16] = '{0, 32'h1000, 2'b00, 2'b10, 2'b00, 32'h0, 32'h55550001, 0, 2'b00, 1, 0, 32'h55550001};

        rst_n = 1'b0;
        m_req = 0; m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
        s_gnt = 0; s_rvalid = 0; s_err = 0; s_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt",    32'(m_gnt),    32'd0);
        chk("rst_rvalid", 32'(m_rvalid), 32'd0);
        chk("rst_err",    32'(m_err),    32'd0);
        chk("rst_sreq",   32'(s_req),    32'd0);
        chk("rst_rdata",  m_rdata,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].req, tbl[i].addr, tbl[i].sgnt, tbl[i].srv, tbl[i].serr, tbl[i].rd0, tbl[i].rd1);
            chk($sformatf("tbl%0d_gnt", i),    32'(m_gnt),    32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_sreq", i),   32'(s_req),    32'(tbl[i].sreq));
            chk($sformatf("tbl%0d_rvalid", i), 32'(m_rvalid), 32'(tbl[i].rvalid));
            chk($sformatf("tbl%0d_err", i),    32'(m_err),    32'(tbl[i].err));
            chk($sformatf("tbl%0d_rdata", i),  m_rdata,       tbl[i].rdata);
            model_check();
            model_step();
        end

        // Reset with two entries outstanding
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h0040, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
            chk("pre_rst_gnt", 32'(m_gnt), 32'd1);
            model_check();
            model_step();
        end
        @(negedge clk);
        rst_n    = 1'b0;
        m_req    = 1'b1;
        s_gnt    = 2'b01;
        s_rvalid = 2'b01;
        s_rdata  = {32'h0, 32'hBEEF0000};
        #1;
        chk("inrst_gnt",    32'(m_gnt),    32'd0);
        chk("inrst_sreq",   32'(s_req),    32'd0);
        chk("inrst_rvalid", 32'(m_rvalid), 32'd0);
        chk("inrst_err",    32'(m_err),    32'd0);
        chk("inrst_rdata",  m_rdata,       32'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_req    = 1'b0;
        s_gnt    = 2'b00;
        s_rvalid = 2'b01;
        s_err    = 2'b01;
        s_rdata  = {32'h0, 32'hDEAD0000};
        #1;
        chk("late_rvalid", 32'(m_rvalid), 32'd0);
        chk("late_rdata",  m_rdata,       32'd0);
        model_check();
        model_step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 2);
            if (sel == 0)      a = {20'h0, 12'($urandom)};
            else if (sel == 1) a = {20'h1, 12'($urandom)};
            else               a = {20'($urandom_range(2, 20'hFFFFF)), 12'($urandom)};
            drive(1'($urandom), a, 2'($urandom),
                  {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                  2'($urandom), $urandom, $urandom);
            model_check();
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/data_bus_demux.md
DATA_BUS_DEMUX -- requirements
Module: data_bus_demux

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of downstream slave ports, legal range 1..8.
REQ-002 Parameter ADDR_WIDTH, default 32: width of the address bus.
REQ-003 Parameter MAX_OUTSTANDING, default 2: depth of the response-tracking FIFO, legal range 1..8.
REQ-004 Parameter SLAVE_BASE, default all zero: NUM_SLAVES x ADDR_WIDTH packed array of slave base addresses.
REQ-005 Parameter SLAVE_MASK, default all zero: NUM_SLAVES x ADDR_WIDTH packed array of slave address masks.
REQ-006 Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-007 clk  input  1  system clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 m_req, m_we  input  1 each  master request and write enable.
REQ-010 m_be  input  4  byte enables; m_addr  input  ADDR_WIDTH; m_wdata  input  32.
REQ-011 m_gnt, m_rvalid, m_err  output  1 each  grant, response valid, response error.
REQ-012 m_rdata  output  32  response read data.
REQ-013 s_req  output  NUM_SLAVES  per-slave request, one-hot or zero.
REQ-014 s_we  output  1; s_be  output  4; s_addr  output  ADDR_WIDTH; s_wdata  output  32; all broadcast to every slave.
REQ-015 s_gnt, s_rvalid, s_err  input  NUM_SLAVES each  per-slave grant, response valid, response error.
REQ-016 s_rdata  input  NUM_SLAVES*32  per-slave read data, slave i at bits [32i+31:32i].

Function
REQ-017 Slave i hits when (m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]; when several hit, the lowest index wins; when none hits, the request is a decode error.
REQ-018 s_req[i] = m_req & hit[i] & accept_ok, where accept_ok = FIFO not full & (FIFO empty | tail target == decoded target).
REQ-019 m_gnt = accept_ok & (hit ? s_gnt[target] : m_req); decode errors are granted combinationally in the same cycle.
REQ-020 Each handshake (m_req & m_gnt) pushes its target id (0..NUM_SLAVES-1, or NUM_SLAVES for a decode error) into the tracking FIFO.
REQ-021 Target-change rule: a request to a target different from the tail entry stalls (m_gnt=0) until the FIFO drains, which guarantees in-order responses.
REQ-022 For a head entry that is a slave id h: m_rvalid = s_rvalid[h], m_rdata = s_rdata[h], m_err = s_err[h].
REQ-023 For a head entry that is a decode error: m_rvalid = 1, m_err = 1, m_rdata = 0, no earlier than one cycle after its grant.
REQ-024 The head is popped in every cycle m_rvalid = 1; a push and pop in the same cycle leave the occupancy unchanged.
REQ-025 When the FIFO is empty: m_rvalid = 0, m_err = 0, m_rdata = 0.
REQ-026 s_rvalid from a slave other than the head target is ignored.
REQ-027 FIFO pointers wrap modulo MAX_OUTSTANDING; the occupancy counter is $clog2(MAX_OUTSTANDING+1) bits wide and never exceeds MAX_OUTSTANDING.
REQ-028 When full, m_gnt = 0 and s_req = 0 until a pop occurs; a pop in the same cycle does not re-enable the grant within that cycle.

Reset
REQ-029 While rst_n = 0: FIFO empty, pointers and counter at 0; outputs m_gnt, m_rvalid, m_err, s_req at 0; m_rdata at 0.
REQ-030 Assertion of rst_n mid-transaction discards all outstanding entries, and late slave responses after reset are ignored.

Configuration
REQ-031 With macro DATA_BUS_INTG_EN defined, the module adds ports m_wdata_intg (input 7), s_wdata_intg (output 7, broadcast), s_rdata_intg (input NUM_SLAVES*7) and m_rdata_intg (output 7), muxed on the same path as rdata.
REQ-032 With DATA_BUS_INTG_EN defined, a decode-error response drives m_rdata_intg with the 7-bit SECDED (39,32) check value of 32'h0.
REQ-033 Without DATA_BUS_INTG_EN, the integrity ports do not exist and behaviour is otherwise identical.

Verification
REQ-034 NUM_SLAVES=2, BASE={0x0,0x1000}, MASK=0xFFFFF000; read 0x1004 with s_gnt[1]=1 -> s_req=2'b10 and m_gnt=1 in the same cycle; s_rvalid[1] with rdata 0xCAFE0001 -> m_rvalid=1, m_rdata=0xCAFE0001.
REQ-035 Read 0x8000 (unmapped) -> m_gnt=1 in the same cycle, s_req=0; next cycle m_rvalid=1, m_err=1, m_rdata=0.
REQ-036 MAX_OUTSTANDING=2, two back-to-back requests to slave 0 with responses withheld -> third request sees m_gnt=0 until the first s_rvalid[0].
REQ-037 Request to slave 0 outstanding, then request to slave 1 -> m_gnt=0 and s_req[1]=0 until slave 0 responds, then granted.
REQ-038 rst_n pulsed low with 2 entries outstanding -> all outputs 0; a subsequent s_rvalid[0] produces no m_rvalid.
